// File: rtl/pwm_ctrl_pkg.sv
// Shared types and defaults for the PWM duty scheduler: duty width, slew step,
// link-loss timeout and the controller state encoding.
package pwm_ctrl_pkg;

    localparam int unsigned DUTY_W                  = 8;
    localparam int unsigned STEP_DEFAULT            = 4;
    localparam int unsigned TIMEOUT_PERIODS_DEFAULT = 1000;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StTrack = 2'd1,
        StFault = 2'd2
    } state_e;

endpackage

// File: rtl/pwm_ramp_channel.sv
// One PWM channel: moves duty toward target by at most STEP per step_en,
// clamping at the target so it never overshoots, wraps or underflows.
module pwm_ramp_channel #(
    parameter int unsigned DUTY_W = 8,
    parameter int unsigned STEP   = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DUTY_W-1:0] target,
    input  logic              step_en,
    output logic [DUTY_W-1:0] duty,
    output logic              at_target
);

    localparam logic [DUTY_W:0] StepExt = STEP[DUTY_W:0];

    logic [DUTY_W-1:0] duty_q, duty_d;
    logic [DUTY_W:0]   up_sum, down_diff;

    always_comb begin
        duty_d    = duty_q;
        up_sum    = {1'b0, duty_q} + StepExt;
        down_diff = {1'b0, duty_q} - StepExt;
        if (step_en) begin
            if (duty_q < target) begin
                duty_d = (up_sum > {1'b0, target}) ? target : up_sum[DUTY_W-1:0];
            end else if (duty_q > target) begin
                // MSB set means the subtraction went below zero
                duty_d = (down_diff[DUTY_W] || (down_diff < {1'b0, target})) ?
                         target : down_diff[DUTY_W-1:0];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            duty_q <= '0;
        end else begin
            duty_q <= duty_d;
        end
    end

    assign duty      = duty_q;
    assign at_target = (duty_q == target);

endmodule

// File: rtl/pwm_duty_scheduler.sv
// Frame-driven duty controller: latches validated targets, slews both PWM
// channels on period boundaries and ramps to zero when the link goes quiet.
module pwm_duty_scheduler #(
    parameter int unsigned DUTY_W          = pwm_ctrl_pkg::DUTY_W,
    parameter int unsigned STEP            = pwm_ctrl_pkg::STEP_DEFAULT,
    parameter int unsigned TIMEOUT_PERIODS = pwm_ctrl_pkg::TIMEOUT_PERIODS_DEFAULT,
    parameter int unsigned CNT_W           = 10
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              frame_valid,
    input  logic              frame_error,
    input  logic [DUTY_W-1:0] frame_duty1,
    input  logic [DUTY_W-1:0] frame_duty2,
    input  logic              period_start,
    output logic [DUTY_W-1:0] duty1_out,
    output logic [DUTY_W-1:0] duty2_out,
    output logic              busy,
    output logic              timeout_flag,
    output logic [7:0]        err_count
);
    import pwm_ctrl_pkg::*;

    localparam logic [CNT_W-1:0] TimeoutCnt = TIMEOUT_PERIODS[CNT_W-1:0];

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  wdog_q, wdog_d;
    logic [DUTY_W-1:0] target1_q, target1_d, target2_q, target2_d;
    logic [7:0]        err_q, err_d;
    logic              good_frame, bad_frame;
    logic              at1, at2;

    assign good_frame = frame_valid & ~frame_error;
    assign bad_frame  = frame_valid & frame_error;

    always_comb begin
        state_d   = state_q;
        wdog_d    = wdog_q;
        target1_d = target1_q;
        target2_d = target2_q;
        err_d     = err_q;

        if (bad_frame && (err_q != 8'hFF)) begin
            err_d = err_q + 8'd1;
        end

        case (state_q)
            StIdle: ;
            StTrack: begin
                if (period_start) begin
                    wdog_d = wdog_q + CNT_W'(1);
                    if (wdog_d == TimeoutCnt) begin
                        state_d   = StFault;
                        target1_d = '0;
                        target2_d = '0;
                    end
                end
            end
            StFault: begin
                target1_d = '0;
                target2_d = '0;
            end
            default: state_d = StIdle;
        endcase

        // A good frame overrides the watchdog increment and any expiry at the same edge
        if (good_frame) begin
            target1_d = frame_duty1;
            target2_d = frame_duty2;
            wdog_d    = '0;
            state_d   = StTrack;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= StIdle;
            wdog_q    <= '0;
            target1_q <= '0;
            target2_q <= '0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            wdog_q    <= wdog_d;
            target1_q <= target1_d;
            target2_q <= target2_d;
            err_q     <= err_d;
        end
    end

    pwm_ramp_channel #(
        .DUTY_W(DUTY_W),
        .STEP  (STEP)
    ) u_ramp1 (
        .CLK      (CLK),
        .RST      (RST),
        .target   (target1_q),
        .step_en  (period_start),
        .duty     (duty1_out),
        .at_target(at1)
    );

    pwm_ramp_channel #(
        .DUTY_W(DUTY_W),
        .STEP  (STEP)
    ) u_ramp2 (
        .CLK      (CLK),
        .RST      (RST),
        .target   (target2_q),
        .step_en  (period_start),
        .duty     (duty2_out),
        .at_target(at2)
    );

    assign busy         = ~at1 | ~at2;
    assign timeout_flag = (state_q == StFault);
    assign err_count    = err_q;

endmodule

// File: tb/tb_pwm_duty_scheduler.sv
// Directed bench for pwm_duty_scheduler with STEP=4, TIMEOUT_PERIODS=8 and a
// period_start pulse every 16 clocks; expected values are hand-derived.
module tb_pwm_duty_scheduler;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       frame_valid = 1'b0;
    logic       frame_error = 1'b0;
    logic [7:0] frame_duty1 = '0;
    logic [7:0] frame_duty2 = '0;
    logic       period_start = 1'b0;
    logic [7:0] duty1_out, duty2_out;
    logic       busy, timeout_flag;
    logic [7:0] err_count;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 CLK = ~CLK;

    pwm_duty_scheduler #(
        .DUTY_W         (8),
        .STEP           (4),
        .TIMEOUT_PERIODS(8),
        .CNT_W          (10)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .frame_valid (frame_valid),
        .frame_error (frame_error),
        .frame_duty1 (frame_duty1),
        .frame_duty2 (frame_duty2),
        .period_start(period_start),
        .duty1_out   (duty1_out),
        .duty2_out   (duty2_out),
        .busy        (busy),
        .timeout_flag(timeout_flag),
        .err_count   (err_count)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // 15 idle clocks, then a one-cycle period_start pulse
    task automatic period();
        repeat (15) tick();
        period_start = 1'b1;
        tick();
        period_start = 1'b0;
    endtask

    task automatic send_frame(input logic err, input logic [7:0] d1, input logic [7:0] d2);
        frame_valid = 1'b1;
        frame_error = err;
        frame_duty1 = d1;
        frame_duty2 = d2;
        tick();
        frame_valid = 1'b0;
        frame_error = 1'b0;
    endtask

    task automatic frame_with_period(input logic [7:0] d1, input logic [7:0] d2);
        repeat (15) tick();
        frame_valid  = 1'b1;
        frame_duty1  = d1;
        frame_duty2  = d2;
        period_start = 1'b1;
        tick();
        frame_valid  = 1'b0;
        period_start = 1'b0;
    endtask

    initial begin
        int exp_d;

        // Reset state
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
        check("rst_duty1", duty1_out, 0);
        check("rst_duty2", duty2_out, 0);
        check("rst_busy", busy, 0);
        check("rst_timeout", timeout_flag, 0);
        check("rst_err", err_count, 0);

        // Basic ramp 0 -> 10 / 0 -> 3
        send_frame(1'b0, 8'd10, 8'd3);
        check("t1_latch_duty1", duty1_out, 0);
        check("t1_busy_before", busy, 1);
        period();
        check("t1_p1_duty1", duty1_out, 4);
        check("t1_p1_duty2", duty2_out, 3);
        check("t1_p1_busy", busy, 1);
        period();
        check("t1_p2_duty1", duty1_out, 8);
        period();
        check("t1_p3_duty1", duty1_out, 10);
        check("t1_p3_busy", busy, 0);

        // Climb to 254, then saturate at 255 without wrapping
        repeat (61) begin
            send_frame(1'b0, 8'd254, 8'd3);
            period();
        end
        check("t2_at254", duty1_out, 254);
        send_frame(1'b0, 8'd255, 8'd3);
        period();
        check("t2_at255", duty1_out, 255);
        check("t2_busy255", busy, 0);

        // Ramp down 255 -> 3 -> 0 without underflow
        exp_d = 255;
        repeat (64) begin
            send_frame(1'b0, 8'd0, 8'd3);
            check("t2_busy_ramp", busy, 1);
            period();
            exp_d = (exp_d > 4) ? exp_d - 4 : 0;
            check("t2_down_duty1", duty1_out, exp_d);
        end
        check("t2_end_busy", busy, 0);

        // Bad frames: discarded, counted, saturating
        send_frame(1'b1, 8'd200, 8'd200);
        check("t3_err1", err_count, 1);
        check("t3_busy_bad", busy, 0);
        period();
        check("t3_duty_unchanged", duty1_out, 0);
        frame_error = 1'b1;
        tick();
        frame_error = 1'b0;
        check("t3_err_no_valid", err_count, 1);
        repeat (299) send_frame(1'b1, 8'd200, 8'd200);
        check("t3_err_sat", err_count, 255);
        send_frame(1'b1, 8'd200, 8'd200);
        check("t3_err_sat_hold", err_count, 255);
        check("t3_duty_after_bad", duty1_out, 0);

        // Link loss: timeout on the 8th period_start, then ramp to 0
        send_frame(1'b0, 8'd20, 8'd20);
        repeat (7) period();
        check("t4_p7_timeout", timeout_flag, 0);
        check("t4_p7_duty1", duty1_out, 20);
        period();
        check("t4_p8_timeout", timeout_flag, 1);
        check("t4_p8_duty1", duty1_out, 20);
        check("t4_p8_busy", busy, 1);
        period();
        check("t4_p9_duty1", duty1_out, 16);
        check("t4_p9_duty2", duty2_out, 16);
        send_frame(1'b0, 8'd40, 8'd0);
        check("t4_recover_timeout", timeout_flag, 0);
        check("t4_recover_hold", duty1_out, 16);
        period();
        check("t4_resume1", duty1_out, 20);
        period();
        check("t4_resume2", duty1_out, 24);

        // Frame coincident with period_start uses the old target for that step
        send_frame(1'b0, 8'd12, 8'd0);
        repeat (3) period();
        check("t5_setup12", duty1_out, 12);
        send_frame(1'b0, 8'd20, 8'd0);
        frame_with_period(8'd0, 8'd0);
        check("t5_old_target", duty1_out, 16);
        period();
        check("t5_new_target", duty1_out, 12);

        // Reset mid-ramp, then IDLE holds with the watchdog off
        repeat (22) begin
            send_frame(1'b0, 8'd200, 8'd0);
            period();
        end
        check("t6_mid100", duty1_out, 100);
        check("t6_mid_busy", busy, 1);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("t6_rst_duty1", duty1_out, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_timeout", timeout_flag, 0);
        check("t6_rst_err", err_count, 0);
        repeat (10) period();
        check("t6_idle_duty1", duty1_out, 0);
        check("t6_idle_timeout", timeout_flag, 0);
        send_frame(1'b0, 8'd8, 8'd0);
        period();
        check("t6_after_frame", duty1_out, 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
